uart_tx_fifo: RTL and testbench

Byte buffer between message producers (button-triggered string senders, future command responders) and the UART transmitter. It accepts bytes at up to one per clock and drains them one at a time through the transmitter's data/data_ready/sampled handshake. It inserts a programmable idle gap between bytes, so producers no longer sequence the transmitter themselves.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 118 +++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-side FSM encoding and default sizing.
package uart_pkg;

   localparam int UART_WIDTH            = 8;
   localparam int DEFAULT_TX_FIFO_DEPTH = 16;
   localparam int DEFAULT_TX_GAP        = 2;

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_WAIT_ACK     = 2'd1,
      S_WAIT_RELEASE = 2'd2,
      S_GAP          = 2'd3
   } tx_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock byte store with registered occupancy flags and an overflow pulse.
// The head entry is visible combinationally on rd_data; rd_en consumes it.
module sync_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_TX_FIFO_DEPTH,
   parameter int WIDTH = UART_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_overflow;
   logic [CW-1:0]    w_count_nxt;
   logic             w_wr_acc;
   logic             w_rd_acc;

   // Acceptance uses the registered full flag, so a same-cycle pop never frees room for a write.
   assign w_wr_acc = wr_en & ~r_full;
   assign w_rd_acc = rd_en & ~r_empty;

   // Next occupancy: write and pop together leave the count unchanged.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, count and flags; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CW'(DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_overflow <= wr_en & r_full;
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter through its data_ready/sampled handshake,
// with a programmable idle gap between consecutive bytes.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_TX_FIFO_DEPTH,
   parameter int WIDTH = UART_WIDTH,
   parameter int GAP   = DEFAULT_TX_GAP
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [WIDTH-1:0]         tx_data,
   output logic                     tx_data_ready,
   input  logic                     tx_sampled
);

   localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0]   GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   logic [GW-1:0]    r_gap_cnt;
   logic [WIDTH-1:0] r_tx_data;
   logic             r_tx_data_ready;
   logic [WIDTH-1:0] w_head;
   logic             w_pop;
   logic             w_ack;
   logic             w_gap_clr;
   logic             w_gap_inc;

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .rd_en    (w_pop),
      .rd_data  (w_head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   // Handshake sequencing: offer, wait for sampled, wait for release, then idle gap.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_ack       = 1'b0;
      w_gap_clr   = 1'b0;
      w_gap_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!empty && !tx_sampled) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_sampled) begin
               w_ack       = 1'b1;
               w_state_nxt = S_WAIT_RELEASE;
            end
         end
         S_WAIT_RELEASE: begin
            if (!tx_sampled) begin
               if (GAP == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_clr   = 1'b1;
                  w_state_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            else                       w_gap_inc   = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset abandons any byte in flight and drops the request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Gap counter, request level and presented byte; tx_data only changes on a pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gap_cnt       <= '0;
         r_tx_data       <= '0;
         r_tx_data_ready <= 1'b0;
      end else begin
         if (w_gap_clr)      r_gap_cnt <= '0;
         else if (w_gap_inc) r_gap_cnt <= r_gap_cnt + 1'b1;
         if (w_pop) begin
            r_tx_data       <= w_head;
            r_tx_data_ready <= 1'b1;
         end else if (w_ack) begin
            r_tx_data_ready <= 1'b0;
         end
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_data_ready = r_tx_data_ready;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle table for handshake timing, transmitter model with scoreboard.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] wr_data;
   logic             wr_en;
   logic             full;
   logic             empty;
   logic [4:0]       count;
   logic             overflow;
   logic [WIDTH-1:0] tx_data;
   logic             tx_data_ready;
   logic             tx_sampled;

   logic tx_en;      // 1: transmitter model drives tx_sampled, 0: test drives it
   logic t_sampled;
   logic m_sampled;
   assign tx_sampled = tx_en ? m_sampled : t_sampled;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb [$];
   int n_deliv = 0;
   int ack_dly = 5;
   int hold_cyc = 3;
   bit chk_gap = 1'b0;
   bit got_req = 1'b0;
   bit m_busy = 1'b0;
   int peak;
   int cnt_viol;

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       smp;
      logic [4:0] cnt;
      logic       emp;
      logic       rdy;
      logic [7:0] txd;
   } vec_t;
   vec_t tbl [26];

   uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .GAP(GAP)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .overflow      (overflow),
      .tx_data       (tx_data),
      .tx_data_ready (tx_data_ready),
      .tx_sampled    (tx_sampled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while (!(sb.size() == 0 && !m_busy && !tx_data_ready && empty) && k < budget) begin
         @(posedge clk); #1;
         k++;
         if (count > peak) peak = count;
         if (count > DEPTH) cnt_viol++;
      end
      chk({name, "_drain_in_time"}, 32'(k < budget), 32'd1);
   endtask

   // Transmitter model: acks each request after ack_dly cycles, holds sampled hold_cyc cycles.
   initial begin
      m_sampled = 1'b0;
      forever begin
         if (!got_req) begin
            @(posedge clk); #1;
         end
         got_req = 1'b0;
         if (tx_en && tx_data_ready) begin
            logic [8:0] exp9;
            m_busy = 1'b1;
            repeat (ack_dly) begin
               @(posedge clk); #1;
            end
            exp9 = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
            chk("tx_byte", {23'd0, tx_data_ready, 1'b0, tx_data}, {23'd0, 1'b1, exp9});
            n_deliv++;
            m_sampled = 1'b1;
            @(posedge clk); #1;
            chk("ready_fall", 32'(tx_data_ready), 32'd0);
            repeat (hold_cyc - 1) begin
               @(posedge clk); #1;
            end
            m_sampled = 1'b0;
            if (chk_gap && sb.size() > 0) begin
               int n;
               n = 0;
               do begin
                  @(posedge clk); #1;
                  n++;
               end while (!tx_data_ready && n < 20);
               chk("gap_spacing", n, GAP + 2);
               if (tx_data_ready) got_req = 1'b1;
            end
            m_busy = 1'b0;
         end
      end
   end

   // Global time bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      string msg;
      int    bad;
      int    base;
      int    wi;
      int    guard;
      logic [7:0] b;

      rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_en = 1'b0; t_sampled = 1'b0;
      msg = "Hello World ";

      // cycle table: {wr, data, sampled} -> {count, empty, ready, tx_data} after the edge
      tbl[0]  = '{1'b1, 8'h48, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h48};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h48};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h48};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h48};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h48};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h48};
      tbl[7]  = '{1'b1, 8'h49, 1'b1, 5'd1, 1'b0, 1'b0, 8'h48};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h48};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 8'h48};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 8'h48};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 8'h48};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h49};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h49};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h49};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h49};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h49};
      tbl[17] = '{1'b1, 8'h50, 1'b1, 5'd1, 1'b0, 1'b0, 8'h49};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h49};
      tbl[19] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h49};
      tbl[20] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h50};
      tbl[21] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h50};
      tbl[22] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h50};
      tbl[23] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h50};
      tbl[24] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h50};
      tbl[25] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h50};

      // reset state and quiet idle
      @(posedge clk); #1;
      chk("reset_state", {18'd0, count, empty, full, overflow, tx_data_ready, tx_data},
          {18'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      @(negedge clk); rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (tx_data_ready || !empty || count != 0) bad++;
      end
      chk("idle_20_cycles", bad, 0);

      // single byte latency, handshake, gap spacing, sampled-high hold-off
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         wr_en = tbl[i].wr; wr_data = tbl[i].d; t_sampled = tbl[i].smp;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", i), {17'd0, count, empty, tx_data_ready, tx_data},
             {17'd0, tbl[i].cnt, tbl[i].emp, tbl[i].rdy, tbl[i].txd});
      end
      @(negedge clk); wr_en = 1'b0; t_sampled = 1'b0;

      // burst "Hello World " with model transmitter
      @(negedge clk);
      tx_en = 1'b1; chk_gap = 1'b1; ack_dly = 5; hold_cyc = 3; peak = 0; cnt_viol = 0;
      base = n_deliv;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_data = msg[i]; sb.push_back(msg[i]);
         @(posedge clk); #1;
         if (count > peak) peak = count;
      end
      @(negedge clk); wr_en = 1'b0;
      wait_drain("burst", 2000);
      chk("burst_peak", 32'(peak == 11 || peak == 12), 32'd1);
      chk("burst_delivered", n_deliv - base, 12);

      // overflow: transmitter holds sampled high so nothing pops
      @(negedge clk); tx_en = 1'b0; t_sampled = 1'b1; chk_gap = 1'b0;
      @(negedge clk);
      for (int v = 1; v <= 17; v++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_data = 8'(v);
         if (v <= 16) sb.push_back(8'(v));
         @(posedge clk); #1;
         if (v == 15) chk("not_full_15", {25'd0, full, overflow, count}, {25'd0, 1'b0, 1'b0, 5'd15});
         if (v == 16) chk("full_at_16", {25'd0, full, overflow, count}, {25'd0, 1'b1, 1'b0, 5'd16});
         if (v == 17) chk("ovf_pulse", {25'd0, full, overflow, count}, {25'd0, 1'b1, 1'b1, 5'd16});
      end
      @(negedge clk); wr_en = 1'b0;
      @(posedge clk); #1;
      chk("ovf_one_cycle", {30'd0, overflow, tx_data_ready}, 32'd0);
      @(negedge clk);
      ack_dly = 2; hold_cyc = 2; tx_en = 1'b1; base = n_deliv;
      wait_drain("ovf", 3000);
      chk("ovf_delivered", n_deliv - base, 16);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (tx_data_ready) bad++;
      end
      chk("no_extra_byte", bad, 0);

      // continuous write and drain, 40 bytes across pointer wraps
      ack_dly = 1; hold_cyc = 1; peak = 0; cnt_viol = 0; base = n_deliv;
      wi = 0; guard = 0;
      while (wi < 40 && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (!full) begin
            b = 8'(128 + wi);
            wr_en = 1'b1; wr_data = b; sb.push_back(b); wi++;
         end else begin
            wr_en = 1'b0;
         end
         @(posedge clk); #1;
         if (count > peak) peak = count;
         if (count > DEPTH) cnt_viol++;
      end
      @(negedge clk); wr_en = 1'b0;
      chk("cont_all_written", wi, 40);
      wait_drain("cont", 5000);
      chk("cont_delivered", n_deliv - base, 40);
      chk("cont_count_bound", {31'd0, 1'(peak <= DEPTH && cnt_viol == 0)}, 32'd1);

      // asynchronous reset while a byte is being offered with 5 queued
      @(negedge clk); tx_en = 1'b0; t_sampled = 1'b0;
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_data = 8'(8'hA0 + v);
         @(posedge clk); #1;
      end
      @(negedge clk); wr_en = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset", {18'd0, tx_data_ready, count, tx_data}, {18'd0, 1'b1, 5'd5, 8'hA0});
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("reset_async", {16'd0, tx_data_ready, count, empty, full, tx_data},
          {16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00});
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      tx_en = 1'b1; ack_dly = 5; hold_cyc = 3; base = n_deliv;
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h21; sb.push_back(8'h21);
      @(negedge clk); wr_en = 1'b0;
      wait_drain("post_reset", 500);
      chk("post_reset_delivered", n_deliv - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
